// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, controller state encoding and address-field
// helpers for the direct-mapped write-back cache controller.
// Address layout: {tag[7:0], index[2:0], offset[4:0]}.
package cache_pkg;

  localparam int ADDR_W  = 16;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 5;
  localparam int DATA_W  = 8;
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int SRAM_AW = IDX_W + OFF_W;
  localparam int N_BLK   = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    HIT_RD,
    HIT_WR,
    WB_RD,
    WB_WR,
    FILL,
    FILL_END
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: bundles the three buses around the cache controller.
//   CPU  : cpu_cs, cpu_wr_rd, cpu_addr, cpu_din -> ; <- cpu_dout, cpu_rdy
//   SRAM : sram_addr, sram_din, sram_we -> ; <- sram_dout (one cycle latency)
//   MEM  : mem_addr, mem_dout, mem_wr_rd, mem_strb -> ; <- mem_din, mem_ack
// Modport slave is the controller; modport master is the surrounding system.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic                cpu_cs;
  logic                cpu_wr_rd;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_din;
  logic [DATA_W-1:0]   cpu_dout;
  logic                cpu_rdy;

  logic [SRAM_AW-1:0]  sram_addr;
  logic [DATA_W-1:0]   sram_din;
  logic [DATA_W-1:0]   sram_dout;
  logic                sram_we;

  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_dout;
  logic [DATA_W-1:0]   mem_din;
  logic                mem_wr_rd;
  logic                mem_strb;
  logic                mem_ack;

  modport slave (
    input  cpu_cs, cpu_wr_rd, cpu_addr, cpu_din, sram_dout, mem_din, mem_ack,
    output cpu_dout, cpu_rdy, sram_addr, sram_din, sram_we,
           mem_addr, mem_dout, mem_wr_rd, mem_strb
  );

  modport master (
    output cpu_cs, cpu_wr_rd, cpu_addr, cpu_din, sram_dout, mem_din, mem_ack,
    input  cpu_dout, cpu_rdy, sram_addr, sram_din, sram_we,
           mem_addr, mem_dout, mem_wr_rd, mem_strb
  );

endinterface

// File: rtl/cache_tag_store.sv
// cache_tag_store: per-block tag, valid and dirty state.
// Ports:
//   clk, rst         clock, async active-high clear of all state
//   idx              block being looked up / updated
//   tag_q, valid_q,  combinational lookup of block idx
//   dirty_q
//   set_dirty        mark block idx dirty (CPU write hit)
//   fill, fill_tag   install fill_tag at idx, valid=1, dirty=0 (fill done)
module cache_tag_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  output logic [TAG_W-1:0] tag_q,
  output logic             valid_q,
  output logic             dirty_q,
  input  logic             set_dirty,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag
);

  logic [TAG_W-1:0] tags [N_BLK];
  logic [N_BLK-1:0] valid;
  logic [N_BLK-1:0] dirty;

  assign tag_q   = tags[idx];
  assign valid_q = valid[idx];
  assign dirty_q = dirty[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags  <= '{default: '0};
      valid <= '0;
      dirty <= '0;
    end else if (fill) begin
      tags[idx]  <= fill_tag;
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty[idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back cache controller, 8 blocks x 32 bytes.
// Ports:
//   clk, rst            clock, async active-high reset
//   bus (slave)         CPU request, cache SRAM and SDRAM handshake buses
//   hit_cnt, miss_cnt   saturating statistics, only with CACHE_STATS_EN
// Build option: define CACHE_STATS_EN to add the hit/miss counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | cpu_rdy high, waiting for cpu_cs
// COMPARE  | tag lookup, SRAM read of the requested byte in flight
// HIT_RD   | return SRAM byte to cpu_dout
// HIT_WR   | write CPU byte into SRAM, mark block dirty
// WB_RD    | read dirty byte cnt from SRAM
// WB_WR    | write byte cnt to SDRAM, wait for mem_ack
// FILL     | read byte cnt from SDRAM, write it into SRAM on mem_ack
// FILL_END | install new tag, replay the request through COMPARE
module cache_ctrl
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  state_t             state, state_nxt;
  logic [OFF_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_din;
  logic               lat_wr;
  logic [DATA_W-1:0]  dout_r;
  logic               replay;

  logic [TAG_W-1:0]   req_tag, lk_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [OFF_W-1:0]   req_off;
  logic               lk_valid, lk_dirty, hit;
  logic               set_dirty, fill_done;

  logic [SRAM_AW-1:0] sram_addr;
  logic [DATA_W-1:0]  sram_din;
  logic               sram_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_dout;
  logic               mem_wr_rd;
  logic               mem_strb;

  assign req_tag = addr_tag(lat_addr);
  assign req_idx = addr_idx(lat_addr);
  assign req_off = addr_off(lat_addr);
  assign hit     = lk_valid && (lk_tag == req_tag);

  cache_tag_store u_tags (
    .clk       (clk),
    .rst       (rst),
    .idx       (req_idx),
    .tag_q     (lk_tag),
    .valid_q   (lk_valid),
    .dirty_q   (lk_dirty),
    .set_dirty (set_dirty),
    .fill      (fill_done),
    .fill_tag  (req_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_din  <= '0;
      lat_wr   <= 1'b0;
      dout_r   <= '0;
      replay   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && bus.cpu_cs) begin
        lat_addr <= bus.cpu_addr;
        lat_din  <= bus.cpu_din;
        lat_wr   <= bus.cpu_wr_rd;
        replay   <= 1'b0;
      end
      if (state == FILL_END) replay <= 1'b1;
      if (state == HIT_RD)   dout_r <= bus.sram_dout;
    end
  end

  // Outputs are decoded from state so that mem_strb falls as soon as rst
  // clears the state register. SRAM address is held through WB_WR so the
  // byte presented on mem_dout stays stable until mem_ack.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sram_addr = '0;
    sram_din  = '0;
    sram_we   = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    mem_wr_rd = 1'b0;
    mem_strb  = 1'b0;
    set_dirty = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_cs) state_nxt = COMPARE;
      end
      COMPARE: begin
        sram_addr = {req_idx, req_off};
        cnt_nxt   = '0;
        if (hit)           state_nxt = lat_wr ? HIT_WR : HIT_RD;
        else if (lk_dirty) state_nxt = WB_RD;
        else               state_nxt = FILL;
      end
      HIT_RD: begin
        sram_addr = {req_idx, req_off};
        state_nxt = IDLE;
      end
      HIT_WR: begin
        sram_addr = {req_idx, req_off};
        sram_din  = lat_din;
        sram_we   = 1'b1;
        set_dirty = 1'b1;
        state_nxt = IDLE;
      end
      WB_RD: begin
        sram_addr = {req_idx, cnt};
        state_nxt = WB_WR;
      end
      WB_WR: begin
        sram_addr = {req_idx, cnt};
        mem_strb  = 1'b1;
        mem_wr_rd = 1'b1;
        mem_addr  = {lk_tag, req_idx, cnt};
        mem_dout  = bus.sram_dout;
        if (bus.mem_ack) begin
          if (cnt == '1) begin
            cnt_nxt   = '0;
            state_nxt = FILL;
          end else begin
            cnt_nxt   = cnt + OFF_W'(1);
            state_nxt = WB_RD;
          end
        end
      end
      FILL: begin
        sram_addr = {req_idx, cnt};
        mem_strb  = 1'b1;
        mem_addr  = {req_tag, req_idx, cnt};
        if (bus.mem_ack) begin
          sram_we  = 1'b1;
          sram_din = bus.mem_din;
          if (cnt == '1) begin
            cnt_nxt   = '0;
            state_nxt = FILL_END;
          end else begin
            cnt_nxt = cnt + OFF_W'(1);
          end
        end
      end
      FILL_END: begin
        fill_done = 1'b1;
        state_nxt = COMPARE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_dout  = dout_r;
  assign bus.cpu_rdy   = (state == IDLE);
  assign bus.sram_addr = sram_addr;
  assign bus.sram_din  = sram_din;
  assign bus.sram_we   = sram_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_dout  = mem_dout;
  assign bus.mem_wr_rd = mem_wr_rd;
  assign bus.mem_strb  = mem_strb;

`ifdef CACHE_STATS_EN
  // Only the first COMPARE of a request counts; the post-fill replay
  // would otherwise register every miss as a hit as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == COMPARE && !replay) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scoreboard bench for cache_ctrl. A reference model
// queues the expected SDRAM transfers, SRAM writes and CPU completions for
// each request; a monitor pops and compares as the DUT produces them.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  typedef enum {K_MEM_WR, K_MEM_RD, K_SRAM_WR, K_CPU_DONE} kind_t;
  typedef struct {
    kind_t       kind;
    logic [15:0] addr;
    logic [7:0]  data;
    int          busy;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_bad  = 0;
  int  rd_seen = 0;

  // reference model state
  logic [7:0] m_tag   [8];
  logic       m_valid [8];
  logic       m_dirty [8];
  logic [7:0] m_data  [256];
  logic [7:0] m_last;

  function automatic logic [7:0] mem_pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input kind_t k, input logic [15:0] a, input logic [7:0] d, input int b);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 8'h00;
    end
    m_last = 8'h00;
  endtask

  // Hit: COMPARE + HIT_x = 2 busy cycles. Clean miss adds 32 fills of
  // 2 cycles each (this responder acks on the 2nd strobe cycle), FILL_END
  // and the replay COMPARE. Dirty miss adds 32 x (WB_RD + 2-cycle WB_WR).
  task automatic model_txn(input logic wr, input logic [15:0] a, input logic [7:0] d);
    logic [2:0]  idx;
    logic [7:0]  tg;
    logic [4:0]  off;
    logic [4:0]  o;
    logic [7:0]  v;
    int          busy;
    idx  = a[7:5];
    tg   = a[15:8];
    off  = a[4:0];
    busy = 2;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      busy += 66;
      if (m_dirty[idx]) begin
        busy += 96;
        for (int i = 0; i < 32; i++) begin
          o = i[4:0];
          push(K_MEM_WR, {m_tag[idx], idx, o}, m_data[{idx, o}], 0);
        end
      end
      for (int i = 0; i < 32; i++) begin
        o = i[4:0];
        v = mem_pat({tg, idx, o});
        push(K_MEM_RD, {tg, idx, o}, v, 0);
        push(K_SRAM_WR, {8'h00, idx, o}, v, 0);
        m_data[{idx, o}] = v;
      end
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      push(K_SRAM_WR, {8'h00, idx, off}, d, 0);
      m_data[{idx, off}] = d;
      m_dirty[idx] = 1'b1;
    end else begin
      m_last = m_data[{idx, off}];
    end
    push(K_CPU_DONE, 16'h0000, m_last, busy);
  endtask

  task automatic take(input kind_t k, input logic [15:0] a, input logic [7:0] d, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h, required none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (e.kind != K_CPU_DONE) check("event_addr", a, e.addr);
      check("event_data", d, e.data);
      if (e.kind == K_CPU_DONE) check("busy_cycles", b, e.busy);
    end
  endtask

  // cache SRAM: address sampled mid-cycle, data returned just after the edge
  initial begin
    logic [7:0] s_a;
    logic       s_we;
    logic [7:0] s_din;
    logic [7:0] sram_arr [256];
    for (int i = 0; i < 256; i++) sram_arr[i] = 8'hEE;
    bus.sram_dout = 8'h00;
    forever begin
      @(negedge clk);
      s_a = bus.sram_addr; s_we = bus.sram_we; s_din = bus.sram_din;
      @(posedge clk);
      #1;
      if (s_we) sram_arr[s_a] = s_din;
      bus.sram_dout = sram_arr[s_a];
    end
  end

  // SDRAM responder: ack on the second cycle of each strobed request
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_din = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.mem_strb) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wcnt = 1;
      end else begin
        wcnt++;
        if (wcnt >= 2) begin
          bus.mem_ack = 1'b1;
          bus.mem_din = mem_pat(bus.mem_addr);
        end
      end
    end
  end

  // monitor
  initial begin
    int   busy;
    logic prev_rdy;
    busy = 0;
    prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        prev_rdy = 1'b1;
      end else begin
        if (bus.mem_strb && bus.mem_ack) begin
          if (bus.mem_wr_rd) take(K_MEM_WR, bus.mem_addr, bus.mem_dout, 0);
          else begin
            rd_seen++;
            take(K_MEM_RD, bus.mem_addr, bus.mem_din, 0);
          end
        end
        if (bus.sram_we) take(K_SRAM_WR, {8'h00, bus.sram_addr}, bus.sram_din, 0);
        if (!bus.cpu_rdy) busy++;
        else if (!prev_rdy) begin
          take(K_CPU_DONE, 16'h0000, bus.cpu_dout, busy);
          busy = 0;
        end
        prev_rdy = bus.cpu_rdy;
      end
    end
  end

  task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
    int t;
    t = 0;
    model_txn(wr, a, d);
    @(negedge clk);
    while (!bus.cpu_rdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cpu_rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rdy_timeout: cpu_rdy=%0b, required 1", bus.cpu_rdy);
    end
    bus.cpu_cs = 1'b1; bus.cpu_wr_rd = wr; bus.cpu_addr = a; bus.cpu_din = d;
    @(posedge clk);
    #1;
    bus.cpu_cs = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d events pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    bus.cpu_cs = 1'b0; bus.cpu_wr_rd = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_din = 8'h00;
    model_reset();
    #2;
    check("rst_cpu_rdy",   bus.cpu_rdy,   1);
    check("rst_cpu_dout",  bus.cpu_dout,  0);
    check("rst_mem_strb",  bus.mem_strb,  0);
    check("rst_sram_we",   bus.sram_we,   0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_sram_addr", bus.sram_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 16'h1100, 8'h00); drain();   // clean miss, index 0
    issue(1'b1, 16'h1100, 8'hAA); drain();   // write hit
    issue(1'b0, 16'h1100, 8'h00); drain();   // read hit -> 0xAA
    issue(1'b0, 16'h3300, 8'h00); drain();   // dirty miss, write back 0x1100..
    issue(1'b0, 16'h3346, 8'h00); drain();   // clean miss, index 2
    issue(1'b0, 16'h3300, 8'h00); drain();   // index 0 still holds 0x33xx

    // abandon a fill at cnt=10 with reset
    base = rd_seen;
    issue(1'b0, 16'h5520, 8'h00);
    t = 0;
    while (rd_seen < base + 10 && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("fill_progress", rd_seen - base, 10);
    @(posedge clk);
    #2;
    check("abort_mem_addr", bus.mem_addr, 16'h552A);
    check("abort_mem_strb", bus.mem_strb, 1);
    rst = 1'b1;
    #1;
    check("async_mem_strb", bus.mem_strb, 0);
    check("async_cpu_rdy",  bus.cpu_rdy,  1);
    check("async_cpu_dout", bus.cpu_dout, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 16'h5520, 8'h00); drain();   // refill from offset 0

`ifdef CACHE_STATS_EN
    check("hit_cnt",  hit_cnt,  0);
    check("miss_cnt", miss_cnt, 1);
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-back cache controller between the CPU transaction generator and the SDRAM controller. It accepts single-byte CPU read/write transactions, resolves hits from an external synchronous cache SRAM, and on a miss writes back a dirty block and fills the new block byte-by-byte over a strobe/acknowledge memory handshake. Tag, valid and dirty state are held internally.

## Interface
- ADDR_W, 16, CPU/memory byte address width
- IDX_W, 3, index width (8 blocks)
- OFF_W, 5, offset width (32-byte blocks); tag width = ADDR_W-IDX_W-OFF_W = 8
- DATA_W, 8, data width

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_cs  in  1  transaction request
- cpu_wr_rd  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_din  in  DATA_W  write data
- cpu_dout  out  DATA_W  read data
- cpu_rdy  out  1  controller idle / transaction complete
- sram_addr  out  IDX_W+OFF_W  cache SRAM address {index, offset}
- sram_din  out  DATA_W  cache SRAM write data
- sram_dout  in  DATA_W  cache SRAM read data, valid one cycle after sram_addr
- sram_we  out  1  cache SRAM write enable
- mem_addr  out  ADDR_W  SDRAM byte address
- mem_dout  out  DATA_W  SDRAM write data
- mem_din  in  DATA_W  SDRAM read data, valid in mem_ack cycle
- mem_wr_rd  out  1  1 = write, 0 = read
- mem_strb  out  1  memory request, held until mem_ack
- mem_ack  in  1  one-cycle memory completion

## Operation
- Address split: tag = addr[15:8], index = addr[7:5], offset = addr[4:0].
- States: IDLE, COMPARE, HIT_RD, HIT_WR, WB_RD, WB_WR, FILL, FILL_END.
- IDLE: cpu_rdy=1; cpu_cs=1 latches addr, din, wr_rd -> COMPARE. cpu_cs in any other state ignored.
- COMPARE: sram_addr={index,offset}; hit = valid[index] & tag match. Hit read -> HIT_RD; hit write -> HIT_WR; miss with dirty[index] -> WB_RD (cnt=0); clean miss -> FILL (cnt=0).
- HIT_RD: cpu_dout <= sram_dout -> IDLE. HIT_WR: sram_we=1, sram_din=latched din, dirty[index]=1 -> IDLE.
- WB_RD: sram_addr={index,cnt} -> WB_WR. WB_WR: mem_strb=1, mem_wr_rd=1, mem_addr={stored tag,index,cnt}, mem_dout=sram_dout; on mem_ack: cnt==31 -> FILL (cnt=0), else cnt+1 -> WB_RD.
- FILL: mem_strb=1, mem_wr_rd=0, mem_addr={new tag,index,cnt}; on mem_ack: sram_we=1, sram_addr={index,cnt}, sram_din=mem_din; cnt==31 -> FILL_END else cnt+1.
- FILL_END: tag[index]=new tag, valid=1, dirty=0 -> COMPARE (replay resolves as hit).
- cnt is 5-bit; last transfer is cnt==31, no wrap beyond.
- mem_ack while mem_strb=0 ignored. mem_addr/mem_dout/mem_wr_rd stable while mem_strb=1.

## Timing
- Reset: state IDLE, cpu_rdy=1, cpu_dout=0, sram_we=0, mem_strb=0, all addresses/data outputs 0, all valid and dirty bits 0, cnt=0.
- Request accepted on edge E0: cpu_rdy low from cycle 1.
- Hit (read or write): cpu_rdy low cycles 1-2, high cycle 3; read data on cpu_dout from cycle 3, held until next read completes.
- Clean miss: hit latency + 32 FILL handshakes + FILL_END + COMPARE. Dirty miss: adds 32 x (WB_RD + handshake).
- Reset mid-operation: immediate return to reset values; transfer abandoned; mem_strb drops asynchronously.

## Configuration
- CACHE_STATS_EN defined: adds outputs hit_cnt[15:0], miss_cnt[15:0]; incremented once per accepted transaction in first COMPARE (replay COMPARE not counted); saturate at 0xFFFF; cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- cache_pkg: IDX_W/OFF_W/TAG_W constants, state enumeration, address-field extraction functions.
- Sub-module cache_tag_store: tag/valid/dirty array with combinational lookup, synchronous update ports, async clear on rst.

## Test plan
- After reset, read 0x1100 -> 32 mem reads 0x1100..0x111F, no mem writes, cpu_dout = byte supplied for 0x1100, cpu_rdy high.
- Then write 0xAA to 0x1100 -> no mem_strb, sram_we once at SRAM addr 0x00 with 0xAA, cpu_rdy low exactly 2 cycles.
- Then read 0x1100 -> hit, cpu_dout=0xAA at cycle 3, no mem traffic.
- Then read 0x3300 (same index 0) -> 32 mem writes 0x1100..0x111F (first byte 0xAA), then 32 mem reads 0x3300..0x331F.
- Read 0x3346 -> clean miss at index 2, fill 0x3340..0x335F, cpu_dout = byte for offset 6; index 0 untouched.
- Assert rst during FILL cnt=10 -> mem_strb 0, cpu_rdy 1 immediately; re-read of same address misses and refills from offset 0.
